// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + non-overlapping 1-D max-pool over frames of LEN signed values.
// Emits one registered maximum per POOL-wide window, with a shorter final window when LEN % POOL != 0.
module relu_maxpool_stream #(
   parameter int T    = 16,
   parameter int LEN  = 33,
   parameter int POOL = 2,
   parameter int RELU = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [T-1:0] s_data_in_x,
   input  logic         s_valid_x,
   output logic         s_ready_x,
   output logic [T-1:0] m_data_out_y,
   output logic         m_valid_y,
   input  logic         m_ready_y
);

   localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [WW-1:0] WLAST = WW'(POOL - 1);
   localparam logic [PW-1:0] PLAST = PW'(LEN - 1);

   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [T-1:0]  acc_q, acc_d;
   logic [T-1:0]  data_q, data_d;
   logic          valid_q, valid_d;

   logic          accept;
   logic          frame_end;
   logic          close;
   logic [T-1:0]  win_max;
   logic [T-1:0]  clamped;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
   // the output register is free when empty or being drained this cycle.
   assign s_ready_x    = !valid_q || m_ready_y;
   assign m_data_out_y = data_q;
   assign m_valid_y    = valid_q;

   always_comb begin
      accept    = s_valid_x && s_ready_x;
      frame_end = (pos_q == PLAST);
      close     = accept && ((wcnt_q == WLAST) || frame_end);
      // First value of a window seeds the max regardless of the stale accumulator.
      if ((wcnt_q == '0) || ($signed(s_data_in_x) > $signed(acc_q))) begin
         win_max = s_data_in_x;
      end else begin
         win_max = acc_q;
      end
      clamped = ((RELU != 0) && win_max[T-1]) ? '0 : win_max;

      acc_d   = acc_q;
      wcnt_d  = wcnt_q;
      pos_d   = pos_q;
      data_d  = data_q;
      valid_d = valid_q;

      if (m_ready_y) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         acc_d  = win_max;
         wcnt_d = close ? '0 : (wcnt_q + WW'(1));
         pos_d  = frame_end ? '0 : (pos_q + PW'(1));
      end
      if (close) begin
         data_d  = clamped;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q  <= '0;
         pos_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         wcnt_q  <= wcnt_d;
         pos_q   <= pos_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Bench for relu_maxpool_stream: four configurations driven in parallel, checked every cycle
// against a window/frame model plus literal expectations for the directed sequences.
module tb_relu_maxpool_stream;

   logic        clk;
   logic        reset;
   logic [15:0] din  [4];
   logic        sv   [4];
   logic        sr   [4];
   logic [15:0] dout [4];
   logic        mv   [4];
   logic        mr   [4];

   int lenv  [4] = '{5, 5, 33, 4};
   int poolv [4] = '{2, 2, 2, 1};
   int reluv [4] = '{1, 0, 1, 1};

   int          n_pass;
   int          n_total;
   int          cyc;
   logic        rand_done;

   int          win_q  [4][$];
   int          fpos   [4];
   logic [15:0] exp_q  [4][$];
   logic [15:0] got_q  [4][$];
   logic        pend   [4];
   logic [15:0] pend_v [4];
   logic        hold_p [4];
   logic [15:0] hold_v [4];

   relu_maxpool_stream #(.T(16), .LEN(5), .POOL(2), .RELU(1)) u0 (
      .clk(clk), .reset(reset), .s_data_in_x(din[0]), .s_valid_x(sv[0]), .s_ready_x(sr[0]),
      .m_data_out_y(dout[0]), .m_valid_y(mv[0]), .m_ready_y(mr[0]));
   relu_maxpool_stream #(.T(16), .LEN(5), .POOL(2), .RELU(0)) u1 (
      .clk(clk), .reset(reset), .s_data_in_x(din[1]), .s_valid_x(sv[1]), .s_ready_x(sr[1]),
      .m_data_out_y(dout[1]), .m_valid_y(mv[1]), .m_ready_y(mr[1]));
   relu_maxpool_stream #(.T(16), .LEN(33), .POOL(2), .RELU(1)) u2 (
      .clk(clk), .reset(reset), .s_data_in_x(din[2]), .s_valid_x(sv[2]), .s_ready_x(sr[2]),
      .m_data_out_y(dout[2]), .m_valid_y(mv[2]), .m_ready_y(mr[2]));
   relu_maxpool_stream #(.T(16), .LEN(4), .POOL(1), .RELU(1)) u3 (
      .clk(clk), .reset(reset), .s_data_in_x(din[3]), .s_valid_x(sv[3]), .s_ready_x(sr[3]),
      .m_data_out_y(dout[3]), .m_valid_y(mv[3]), .m_ready_y(mr[3]));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s act=0x%0h req=0x%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic check_list(input int i, input string nm, input logic [15:0] ex[$]);
      check({nm, "_count"}, 32'(got_q[i].size()), 32'(ex.size()));
      for (int k = 0; k < ex.size() && k < got_q[i].size(); k++) begin
         check($sformatf("%s_%0d", nm, k), 32'(got_q[i][k]), 32'(ex[k]));
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   // Window contents are collected as plain integers; a window closes when it holds POOL values
   // or the frame has delivered LEN values, and its expected output is the (clamped) maximum.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            win_q[i].delete();
            exp_q[i].delete();
            fpos[i]   = 0;
            pend[i]   = 1'b0;
            hold_p[i] = 1'b0;
         end else begin
            check($sformatf("ready_rule_%0d", i), 32'(sr[i]), 32'(!mv[i] || mr[i]));
            if (hold_p[i]) begin
               check($sformatf("hold_valid_%0d", i), 32'(mv[i]), 32'd1);
               check($sformatf("hold_data_%0d", i), 32'(dout[i]), 32'(hold_v[i]));
            end
            if (pend[i]) begin
               check($sformatf("latency_valid_%0d", i), 32'(mv[i]), 32'd1);
               check($sformatf("latency_data_%0d", i), 32'(dout[i]), 32'(pend_v[i]));
               pend[i] = 1'b0;
            end
            if (mv[i] && mr[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("unexpected_out_%0d", i), 32'(dout[i]), 32'hDEAD_0000);
               end else begin
                  check($sformatf("out_data_%0d", i), 32'(dout[i]), 32'(exp_q[i].pop_front()));
               end
               got_q[i].push_back(dout[i]);
            end
            if (sv[i] && sr[i]) begin
               win_q[i].push_back(int'($signed(din[i])));
               fpos[i]++;
               if (win_q[i].size() == poolv[i] || fpos[i] == lenv[i]) begin
                  int mx;
                  mx = win_q[i][0];
                  foreach (win_q[i][k]) if (win_q[i][k] > mx) mx = win_q[i][k];
                  if (reluv[i] != 0 && mx < 0) mx = 0;
                  exp_q[i].push_back(16'(mx));
                  pend[i]   = 1'b1;
                  pend_v[i] = 16'(mx);
                  win_q[i].delete();
                  if (fpos[i] == lenv[i]) fpos[i] = 0;
               end
            end
            hold_p[i] = mv[i] && !mr[i];
            hold_v[i] = dout[i];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input int i, input int v);
      din[i] = 16'(v);
      sv[i]  = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (sr[i]) begin
            @(posedge clk);
            #1;
            sv[i]  = 1'b0;
            din[i] = 16'($urandom_range(0, 65535));
            return;
         end
         @(posedge clk);
         #1;
      end
      check($sformatf("push_timeout_%0d", i), 32'd0, 32'd1);
      sv[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_got();
      for (int i = 0; i < 4; i++) got_q[i].delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ex[$];
      int t0;
      n_pass = 0;
      n_total = 0;
      cyc = 0;
      rand_done = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din[i] = '0;
         sv[i]  = 1'b0;
         mr[i]  = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_valid_%0d", i), 32'(mv[i]), 32'd0);
         check($sformatf("reset_data_%0d", i), 32'(dout[i]), 32'd0);
         check($sformatf("reset_ready_%0d", i), 32'(sr[i]), 32'd1);
      end
      @(posedge clk);
      #1;

      // Directed full-rate sequences on three configurations at once.
      fork
         begin
            push(0, 3); push(0, -7); push(0, -2); push(0, -9); push(0, 4);
         end
         begin
            push(1, -5); push(1, -3); push(1, -8); push(1, -1); push(1, -6);
         end
         begin
            t0 = cyc;
            push(3, -1); push(3, 0); push(3, 32767); push(3, -32768);
            check("pool1_full_rate_cycles", 32'(cyc - t0), 32'd4);
         end
      join
      idle(4);
      ex = '{16'd3, 16'd0, 16'd4};
      check_list(0, "relu_l5p2", ex);
      ex = '{16'hFFFD, 16'hFFFF, 16'hFFFA};
      check_list(1, "raw_l5p2", ex);
      ex = '{16'd0, 16'd0, 16'd32767, 16'd0};
      check_list(3, "pool1", ex);
      clear_got();

      // Backpressure: first output is held for 10 cycles before being taken.
      mr[0] = 1'b0;
      fork
         begin
            push(0, 10); push(0, 20); push(0, 30); push(0, 40); push(0, 50);
         end
         begin
            int c;
            c = 0;
            while (!mv[0] && c < 100) begin
               @(negedge clk);
               c++;
            end
            check("bp_first_valid_seen", 32'(mv[0]), 32'd1);
            repeat (10) @(posedge clk);
            #1;
            mr[0] = 1'b1;
         end
      join
      idle(4);
      ex = '{16'd20, 16'd40, 16'd50};
      check_list(0, "backpressure", ex);
      clear_got();

      // Reset in the middle of a frame discards the partial window.
      push(0, 1); push(0, 2); push(0, 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midreset_valid_%0d", i), 32'(mv[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      clear_got();
      push(0, 8); push(0, 1); push(0, 2); push(0, 6); push(0, -1);
      idle(4);
      ex = '{16'd8, 16'd6, 16'd0};
      check_list(0, "after_reset", ex);
      clear_got();

      // Random valid/ready over four frames of the default configuration.
      fork
         begin
            for (int n = 0; n < 4 * 33; n++) begin
               int v;
               if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 40) - 20;
               else v = int'($signed(16'($urandom_range(0, 65535))));
               while ($urandom_range(0, 1) == 1) idle(1);
               push(2, v);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               mr[2] = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            mr[2] = 1'b1;
         end
      join
      idle(6);
      check("random_output_count", 32'(got_q[2].size()), 32'd68);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drained_%0d", i), 32'(exp_q[i].size()), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/relu_maxpool_stream.md
Name: relu_maxpool_stream

Overview:
- Streaming ReLU + 1-D max-pool stage that sits directly downstream of a multi-layer conv block (e.g. multi_64_33_9_10_16_14).
- Consumes the conv block's signed T-bit output stream through the same valid/ready handshake.
- Reduces each frame of LEN values to ceil(LEN/POOL) window maxima, with optional ReLU clamp.
- Output stream feeds the next conv stage or the result collector.

Parameters:
T, 16, data width in bits (two's-complement signed)
LEN, 33, values per frame (one conv output row), >= 1
POOL, 2, window size and stride (non-overlapping), 1 <= POOL <= LEN
RELU, 1, 1 = clamp each emitted maximum to >= 0; 0 = pass the raw maximum

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
s_data_in_x  input  T  signed input value
s_valid_x  input  1  input value valid
s_ready_x  output  1  block can accept the input value
m_data_out_y  output  T  signed pooled output value
m_valid_y  output  1  output value valid
m_ready_y  input  1  downstream accepts the output value

Behaviour:
- Reset (sync, active-high): m_valid_y=0, m_data_out_y=0, window count wcnt=0, frame position pos=0, running max acc=0. Reset dominates any same-cycle handshake.
- Reset mid-frame discards the partial window and any unaccepted output; the first post-reset input starts a new frame.
- Input acceptance: a value is taken on a rising edge when s_valid_x && s_ready_x.
- s_ready_x = !m_valid_y || m_ready_y. This is combinational and registers nothing extra.
- Input is therefore stalled only while a completed result is held and not yet accepted.
- On each accepted value:
  - if wcnt==0: acc <= s_data_in_x
  - otherwise: acc <= max(acc, s_data_in_x), using a signed compare
  - wcnt increments and pos increments.
- Window closes when the accepted value makes wcnt==POOL-1, or when pos==LEN-1 (frame end).
- On window close:
  - the registered output loads max(acc, in); with RELU=1 it is clamped so negative results become 0
  - m_valid_y <= 1
  - wcnt <= 0
  - on frame end, pos <= 0
- Partial final window: if LEN mod POOL != 0, the last window has fewer than POOL elements and still emits exactly one output.
- Outputs per frame = ceil(LEN/POOL). Frames repeat back to back with no gap.
- Latency: the output is valid on the edge that accepts the window-closing input (1 cycle after the input is presented with ready high).
- Output hold: while m_valid_y && !m_ready_y, m_data_out_y and m_valid_y stay constant and s_ready_x=0.
- Output release:
  - m_valid_y && m_ready_y with no new close in the same cycle: m_valid_y <= 0.
  - Accept and new close in the same cycle: the new value is loaded and m_valid_y stays 1. Full throughput, no bubble.
- POOL==1: every accepted input produces an output (ReLU-only pass-through, 1-cycle latency).
- Ties: equal values give an identical result. Max of all-equal negatives with RELU=1 gives 0.
- Arithmetic: comparison only, no width growth; output is exactly T bits.
- No state changes on cycles without a handshake. Inputs while s_valid_x=0 are ignored (data may be X).

Test Plan:
- T=16, LEN=5, POOL=2, RELU=1. Inputs 3,-7,-2,-9,4 with valid/ready always high. Required: outputs 3,0,4. Third output is the partial window. Each output m_valid_y appears 1 cycle after the closing input.
- Same config, RELU=0, inputs -5,-3,-8,-1,-6. Required: outputs -3,-1,-6 (0xFFFD,0xFFFF,0xFFFA).
- Default LEN=33, POOL=2, RELU=1. Random valid/ready (~50% each) over 4 frames of random signed values, checked against a reference model. Required: 68 outputs, 17 per frame, zero mismatches, no dropped or duplicated outputs.
- Backpressure: hold m_ready_y=0 for 10 cycles after the first output. Required: s_ready_x=0 and output stable throughout; accepting resumes on the release cycle with no value lost.
- Assert reset for one cycle after 3 inputs of a LEN=5, POOL=2 frame, then send 8,1,2,6,-1. Required: m_valid_y=0 after reset, and outputs are 8,6,0 (new frame, no stale window).
- POOL=1, RELU=1, inputs -1,0,32767,-32768 at full rate. Required: 0,0,32767,0, one per cycle, no stalls.
